// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with dead-time between digits and
// frame-aligned double buffering. Optional leading-zero suppression: SEG_SCAN_LZS_EN.
module seg_scan_ctrl #(
   parameter int DIGITS = 4,
   parameter int TICKS  = 50000,
   parameter int DEAD   = 16,
   localparam int DW    = (DIGITS > 1) ? $clog2(DIGITS) : 1,
   localparam int TW    = $clog2(((TICKS > DEAD) ? TICKS : DEAD) + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic                load,
   input  logic [4*DIGITS-1:0] value,
   input  logic [DIGITS-1:0]   blank,
   output logic [3:0]          sel,
   output logic [DIGITS-1:0]   an,
   output logic [DW-1:0]       digit,
   output logic                frame_start,
   output logic [1:0]          fsm_state
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SHOW = 2'd1;
   localparam logic [1:0] S_DEAD = 2'd2;

   localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS - 1);
   localparam logic [TW-1:0] SHOW_LAST  = TW'(TICKS - 1);
   localparam logic [TW-1:0] DEAD_LAST  = TW'((DEAD > 0) ? DEAD - 1 : 0);

   logic [1:0]          state, state_n;
   logic [TW-1:0]       timer, timer_n;
   logic [DW-1:0]       digit_n, digit_inc;
   logic                fs_n;
   logic [4*DIGITS-1:0] shadow, display, display_n;
   logic [3:0]          sel_n;
   logic [DIGITS-1:0]   an_n;

   assign fsm_state = state;
   assign digit_inc = (digit == LAST_DIGIT) ? '0 : digit + DW'(1);

   // Display only reloads from shadow on the edge that enters digit 0 of a new
   // frame, so the copy always sees the shadow value from before a same-edge load.
   always_comb begin
      state_n   = state;
      timer_n   = timer;
      digit_n   = digit;
      display_n = display;
      fs_n      = 1'b0;
      case (state)
         S_IDLE: begin
            if (en) begin
               state_n   = S_SHOW;
               timer_n   = '0;
               digit_n   = '0;
               display_n = shadow;
               fs_n      = 1'b1;
            end
         end
         S_SHOW: begin
            if (!en) begin
               state_n = S_IDLE;
               timer_n = '0;
               digit_n = '0;
            end else if (timer == SHOW_LAST) begin
               timer_n = '0;
               digit_n = digit_inc;
               if (digit_inc == '0) display_n = shadow;
               if (DEAD == 0) begin
                  state_n = S_SHOW;
                  fs_n    = (digit_inc == '0);
               end else begin
                  state_n = S_DEAD;
               end
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         S_DEAD: begin
            if (!en) begin
               state_n = S_IDLE;
               timer_n = '0;
               digit_n = '0;
            end else if (timer == DEAD_LAST) begin
               state_n = S_SHOW;
               timer_n = '0;
               fs_n    = (digit == '0);
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         default: begin
            state_n = S_IDLE;
            timer_n = '0;
            digit_n = '0;
         end
      endcase
   end

`ifdef SEG_SCAN_LZS_EN
   logic [DW-1:0] lead;

   // Highest digit holding a nonzero nibble; digit 0 is always eligible.
   always_comb begin
      lead = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (display_n[4*k +: 4] != 4'h0) lead = DW'(k);
      end
   end
`endif

   always_comb begin
      sel_n = 4'h0;
      an_n  = '1;
      for (int k = 0; k < DIGITS; k++) begin
         if (state_n != S_IDLE && digit_n == DW'(k)) sel_n = display_n[4*k +: 4];
         if (state_n == S_SHOW && digit_n == DW'(k)) begin
`ifdef SEG_SCAN_LZS_EN
            an_n[k] = blank[k] | (DW'(k) > lead);
`else
            an_n[k] = blank[k];
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         timer       <= '0;
         digit       <= '0;
         sel         <= 4'h0;
         an          <= '1;
         frame_start <= 1'b0;
         shadow      <= '0;
         display     <= '0;
      end else begin
         state       <= state_n;
         timer       <= timer_n;
         digit       <= digit_n;
         sel         <= sel_n;
         an          <= an_n;
         frame_start <= fs_n;
         display     <= display_n;
         if (load) shadow <= value;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (DIGITS=4, TICKS=3, DEAD=2, 20-cycle frame).
// Honours SEG_SCAN_LZS_EN when the expectation model is built.
module tb_seg_scan_ctrl;

   logic        clk;
   logic        reset;
   logic        en;
   logic        load;
   logic [15:0] value;
   logic [3:0]  blank;
   logic [3:0]  sel;
   logic [3:0]  an;
   logic [1:0]  digit;
   logic        frame_start;
   logic [1:0]  fsm_state;

   // Entry layout: {state, an, sel, digit, frame_start}
   logic [12:0] exp_q[$];
   int          checks;
   int          errors;

   seg_scan_ctrl #(.DIGITS(4), .TICKS(3), .DEAD(2)) dut (
      .clk(clk), .reset(reset), .en(en), .load(load), .value(value), .blank(blank),
      .sel(sel), .an(an), .digit(digit), .frame_start(frame_start), .fsm_state(fsm_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic lz_dark(input int d, input logic [15:0] disp);
      int h;
      h = 0;
`ifdef SEG_SCAN_LZS_EN
      for (int k = 0; k < 4; k++) if (disp[4*k +: 4] != 4'h0) h = k;
      return d > h;
`else
      return 1'b0;
`endif
   endfunction

   // Expected outputs at frame position pos (5 cycles per digit: 3 SHOW, 2 DEAD).
   function automatic logic [12:0] exp_at(input int pos, input logic [15:0] disp,
                                          input logic [15:0] nxt, input logic [3:0] blk);
      int          d;
      int          nd;
      logic [3:0]  a;
      logic [15:0] src;
      d = pos / 5;
      if (pos % 5 < 3) begin
         a = 4'b1111;
         if (!blk[d] && !lz_dark(d, disp)) a[d] = 1'b0;
         return {2'd1, a, disp[4*d +: 4], 2'(d), (pos == 0)};
      end
      nd  = (d + 1) % 4;
      src = (nd == 0) ? nxt : disp;
      return {2'd2, 4'b1111, src[4*nd +: 4], 2'(nd), 1'b0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_idle();
      exp_q.push_back({2'd0, 4'b1111, 4'h0, 2'd0, 1'b0});
   endtask

   // Pushes positions 0..npos-1; leaves the DUT just after the edge producing the last one.
   task automatic frame(input logic [15:0] disp, input logic [15:0] nxt, input logic [3:0] blk,
                        input int npos, input int lpos, input logic [15:0] lval);
      for (int p = 0; p < npos; p++) begin
         exp_q.push_back(exp_at(p, disp, nxt, blk));
         load = (p == lpos);
         if (p == lpos) value = lval;
         if (p < npos - 1) tick();
      end
   endtask

   always @(negedge clk) begin
      logic [12:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if ({fsm_state, an, sel, digit, frame_start} !== e) begin
            errors++;
            $display("FAIL scan_out t=%0t got st=%0d an=%b sel=%h digit=%0d fs=%b, expected st=%0d an=%b sel=%h digit=%0d fs=%b",
                     $time, fsm_state, an, sel, digit, frame_start,
                     e[12:11], e[10:7], e[6:3], e[2:1], e[0]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      en     = 1'b0;
      load   = 1'b0;
      value  = 16'h0;
      blank  = 4'b0000;
      tick();
      expect_idle(); tick();
      expect_idle(); reset = 1'b0; en = 1'b1; tick();

      // first frame from an empty display; 0x1234 loaded early, copied at the frame edge
      frame(16'h0000, 16'h1234, 4'b0000, 20, 2, 16'h1234); tick();
      // mid-frame load while digit 2 is lit
      frame(16'h1234, 16'hABCD, 4'b0000, 20, 10, 16'hABCD); tick();
      // load on the same edge as the frame copy lands one frame later
      frame(16'hABCD, 16'hABCD, 4'b0000, 20, 17, 16'h1234); tick();
      frame(16'hABCD, 16'h1234, 4'b0000, 20, -1, 16'h0); blank = 4'b0100; tick();
      frame(16'h1234, 16'h1234, 4'b0100, 20, -1, 16'h0); blank = 4'b0000; tick();

      // drop enable during digit 1 SHOW for 5 cycles
      frame(16'h1234, 16'h1234, 4'b0000, 6, -1, 16'h0);
      en = 1'b0; tick();
      repeat (4) begin expect_idle(); tick(); end
      expect_idle(); en = 1'b1; tick();

      // reset in the DEAD gap after digit 0 clears shadow and display
      frame(16'h1234, 16'h1234, 4'b0000, 4, -1, 16'h0);
      reset = 1'b1; tick();
      expect_idle(); reset = 1'b0; tick();
      frame(16'h0000, 16'h0050, 4'b0000, 20, 2, 16'h0050); tick();
      frame(16'h0050, 16'h0000, 4'b0000, 20, 2, 16'h0000); tick();
      frame(16'h0000, 16'h0000, 4'b0000, 20, -1, 16'h0);

      repeat (2) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one hex-to-segment decoder. Each cycle it drives the decoder's 4-bit select with one digit's nibble and enables that digit's anode, stepping through the digits. Between digits it inserts a dead-time gap to prevent ghosting. New display values are double-buffered so an update never lands partway through a frame.

Parameters:
DIGITS, 4, number of digits scanned; legal range 1..8
TICKS, 50000, clock cycles each digit is lit (SHOW length); must be >= 1
DEAD, 16, clock cycles all anodes are off between digits; 0 removes the gap

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
en  input  1  scan enable
load  input  1  one-cycle strobe; captures value into the shadow register
value  input  4*DIGITS  digit nibbles; digit k is value[4k+3:4k], digit 0 is least significant
blank  input  DIGITS  per-digit force-off mask, 1 = digit dark
sel  output  4  nibble presented to the shared hex decoder
an  output  DIGITS  anode enables, active-low
digit  output  $clog2(DIGITS) (min 1)  index of the current or next digit
frame_start  output  1  one-cycle pulse on the first SHOW cycle of digit 0

Behaviour:
- Reset is synchronous, active-high, and legal at any time, including mid-frame. At the next edge it forces:
  - state=IDLE, an=all 1s, sel=0, digit=0, frame_start=0
  - shadow=0, display=0, timer=0
- Shadow register: when load=1 at an edge, shadow<=value. This happens in every state, including while en=0.
- Display register: display<=shadow only at frame boundaries:
  - on IDLE->SHOW
  - on the transition into the DEAD that precedes digit 0 (or into SHOW of digit 0 when DEAD=0)
- A load and a copy on the same edge: the copy takes the pre-load shadow, and the new value appears one frame later.
- State machine (registered outputs):
  - IDLE: an=all 1s. If en=1, go to SHOW with digit=0, copy shadow to display, frame_start=1 for that first SHOW cycle.
  - SHOW: sel=display[digit]; an=~(1<<digit), or all 1s if blank[digit]=1. Lasts exactly TICKS cycles, then goes to DEAD (or straight to SHOW of the next digit if DEAD=0).
  - DEAD: an=all 1s; digit and sel already show the next digit so the decoder settles. Lasts exactly DEAD cycles, then goes to SHOW.
  - Next digit is (digit+1) mod DIGITS. On wrap to 0: frame copy, and frame_start=1 on digit 0's first SHOW cycle.
- en=0 in SHOW or DEAD: the next edge goes to IDLE with an=all 1s and digit=0. When en returns, scanning restarts at digit 0 with frame_start.
- Frame period is DIGITS*(TICKS+DEAD) cycles.
- DIGITS=1: the single digit repeats; a frame boundary occurs every pass.
- blank affects only an, never timing or sel. blank is sampled combinationally into the registered an each cycle.
- Timer width is $clog2(max(TICKS,DEAD)+1). No counter may overflow at the maximum parameter values.

Optional Feature:
Macro: SEG_SCAN_LZS_EN
- Defined: leading-zero suppression. Compute the highest digit index h with a nonzero display nibble (h=0 if all nibbles are zero). In SHOW, digits with index > h keep an=all 1s. Digit 0 is always eligible, so a value of 0 shows a single "0". Suppression combines with blank by OR.
- Undefined: only blank darkens digits. No extra logic is generated.

Test Plan:
1. Reset and first frame. Parameters DIGITS=4, TICKS=3, DEAD=2. Assert reset, then release with en=1.
   -> an=1111 and sel=0 during reset.
   -> One IDLE cycle, then frame_start=1.
   -> an=1110 for 3 cycles, 1111 for 2 cycles, 1101 for 3 cycles, and so on.
   -> Frame period is 20 cycles.
2. Load value=0x1234, then wait for the next frame_start.
   -> sel sequence 4, 3, 2, 1 paired with an 1110, 1101, 1011, 0111.
   -> In each DEAD, sel already equals the next digit's nibble.
3. Mid-frame load. Issue load 0xABCD while digit 2 is lit with display 0x1234.
   -> Digit 3 still shows 1.
   -> The next frame shows D, C, B, A.
4. blank=0100 with value 0x1234.
   -> an stays 1111 during digit 2's SHOW, while sel=2.
   -> Frame period is unchanged.
5. Drop en during digit 1 SHOW, hold it low 5 cycles, then raise it.
   -> an=1111 from the next edge; digit=0.
   -> After en rises: one IDLE cycle, then frame_start and an=1110.
   -> Also assert reset mid-DEAD: all reset values appear at the next edge.
6. With SEG_SCAN_LZS_EN defined:
   -> value=0x0050: only digits 0 and 1 light.
   -> value=0x0000: only digit 0 lights, with sel=0.
   -> Without the macro, value=0x0050: all four digits light.
